// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin arbiter that time-shares one external
// 16-bit adder among NREQ requesters. Each transaction runs in three phases:
// IDLE (grant and operand capture), ADD (sample the adder's sum) and
// RESP (hold the tagged result until the consumer accepts it).
module adder_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   a_in,
    input  logic [NREQ*W-1:0]   b_in,
    output logic [NREQ-1:0]     gnt,
    output logic [W-1:0]        add_a,
    output logic [W-1:0]        add_b,
    input  logic [W-1:0]        add_s,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [W-1:0]        rsp_sum,
    output logic                rsp_carry,
    output logic                rsp_ovf,
    input  logic                rsp_ready,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg;
    logic [IDW-1:0]   ptr_reg;

    // Unpacked views of the flattened operand buses.
    logic [W-1:0]     a_arr [NREQ];
    logic [W-1:0]     b_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = a_in[gi*W +: W];
            assign b_arr[gi] = b_in[gi*W +: W];
        end
    endgenerate

    logic             win_valid;
    logic [IDW-1:0]   win_idx;

    // Pick the first requester at or above ptr, wrapping around. Scanning
    // the offsets from farthest to nearest lets the nearest hit win.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr_reg) + k) % NREQ]) begin
                win_valid = 1'b1;
                win_idx   = IDW'((int'(ptr_reg) + k) % NREQ);
            end
        end
    end

    // Grant only exists in IDLE; ADD and RESP never expose a grant.
    always_comb begin
        gnt = '0;
        if (state_reg == IDLE && win_valid) begin
            gnt = NREQ'(1) << win_idx;
        end
    end

    assign busy = (state_reg != IDLE);

    // Sequencer: capture operands on grant, sample the sum one cycle later,
    // then hold the response until it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        add_a     <= a_arr[win_idx];
                        add_b     <= b_arr[win_idx];
                        rsp_id    <= win_idx;
                        ptr_reg   <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                        state_reg <= ADD;
                    end
                end
                ADD: begin
                    rsp_sum   <= add_s;
                    // A wrapped unsigned sum is always smaller than either operand.
                    rsp_carry <= (add_s < add_a);
                    rsp_ovf   <= (add_a[W-1] == add_b[W-1]) && (add_s[W-1] != add_a[W-1]);
                    rsp_valid <= 1'b1;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Testbench for adder_share_arbiter: directed corner cases followed by
// randomized transactions, all checked against a behavioural model that
// computes the winner, sum and flags with plain integer arithmetic.
module tb_adder_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W-1:0]      add_s;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_carry;
    logic              rsp_ovf;
    logic              rsp_ready;
    logic              busy;

    int total = 0;
    int bad   = 0;

    // Model state: rotation pointer and per-requester operands.
    int         mptr;
    logic [W-1:0] ta [NREQ];
    logic [W-1:0] tb [NREQ];

    always #5 clk = ~clk;

    // The shared external adder, modelled combinationally.
    assign add_s = add_a + add_b;

    adder_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_ovf   (rsp_ovf),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic load_ops();
        for (int i = 0; i < NREQ; i++) begin
            a_in[i*W +: W] = ta[i];
            b_in[i*W +: W] = tb[i];
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        rsp_ready = 1'b1;
        step();
        step();
        rst  = 1'b0;
        mptr = 0;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_add_a", 32'(add_a), 0);
        chk("rst_add_b", 32'(add_b), 0);
        chk("rst_sum", 32'(rsp_sum), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_flags", {30'd0, rsp_carry, rsp_ovf}, 0);
    endtask

    // One full transaction starting in IDLE; stall = cycles with rsp_ready low.
    task automatic txn(input logic [NREQ-1:0] r, input int stall);
        int w;
        int sa, sb, ssum, usum;
        logic [W-1:0] e_sum;
        logic e_carry, e_ovf;
        load_ops();
        req       = r;
        rsp_ready = (stall == 0);
        #1;
        w = pick(r, mptr);
        chk("gnt", 32'(gnt), 32'(1) << w);
        usum    = int'(ta[w]) + int'(tb[w]);
        e_sum   = W'(usum);
        e_carry = (usum >= 65536);
        sa      = int'($signed(ta[w]));
        sb      = int'($signed(tb[w]));
        ssum    = sa + sb;
        e_ovf   = (ssum > 32767) || (ssum < -32768);
        mptr    = (w + 1) % NREQ;
        step();
        chk("add_gnt", 32'(gnt), 0);
        chk("add_a", 32'(add_a), 32'(ta[w]));
        chk("add_b", 32'(add_b), 32'(tb[w]));
        chk("add_busy", 32'(busy), 1);
        chk("add_valid", 32'(rsp_valid), 0);
        step();
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_id", 32'(rsp_id), 32'(w));
        chk("rsp_sum", 32'(rsp_sum), 32'(e_sum));
        chk("rsp_carry", 32'(rsp_carry), 32'(e_carry));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(e_ovf));
        for (int i = 0; i < stall; i++) begin
            step();
            chk("stall_valid", 32'(rsp_valid), 1);
            chk("stall_sum", 32'(rsp_sum), 32'(e_sum));
            chk("stall_id", 32'(rsp_id), 32'(w));
            chk("stall_gnt", 32'(gnt), 0);
        end
        rsp_ready = 1'b1;
        step();
        chk("idle_valid", 32'(rsp_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        $display("txn req=%b id=%0d a=%h b=%h sum=%h c=%0d v=%0d stall=%0d",
                 r, w, ta[w], tb[w], rsp_sum, rsp_carry, rsp_ovf, stall);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req = '0; rsp_ready = 1'b1; a_in = '0; b_in = '0;
        for (int i = 0; i < NREQ; i++) begin ta[i] = '0; tb[i] = '0; end
        mptr = 0;
        do_reset();

        // Basic add, carry and overflow corners on requester 0.
        ta[0] = 16'h1234; tb[0] = 16'h0101; txn(4'b0001, 0);
        ta[0] = 16'hFFFF; tb[0] = 16'h0002; txn(4'b0001, 0);
        ta[0] = 16'h7FFF; tb[0] = 16'h0001; txn(4'b0001, 0);
        ta[0] = 16'h8000; tb[0] = 16'h8000; txn(4'b0001, 0);

        // Round-robin with all requests held, back to back.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            ta[i] = W'($urandom); tb[i] = W'($urandom);
        end
        for (int n = 0; n < 5; n++) txn(4'b1111, 0);

        // Backpressure, then requester 1 granted right after acceptance.
        ta[1] = 16'h4321; tb[1] = 16'h1111;
        txn(4'b0010, 5);
        txn(4'b0010, 0);

        // Reset during ADD abandons the transaction.
        req = 4'b1111; load_ops(); #1;
        step();
        chk("mid_busy", 32'(busy), 1);
        req = '0;
        rst = 1'b1;
        step();
        rst  = 1'b0;
        mptr = 0;
        #1;
        chk("mid_valid", 32'(rsp_valid), 0);
        chk("mid_busy0", 32'(busy), 0);
        chk("mid_gnt", 32'(gnt), 0);
        chk("mid_add_a", 32'(add_a), 0);
        chk("mid_sum", 32'(rsp_sum), 0);
        txn(4'b1111, 0);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                ta[i] = W'($urandom); tb[i] = W'($urandom);
            end
            txn(NREQ'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
